// File: rtl/vga_sync.sv
// VGA timing generator: divides the system clock down to a pixel strobe, walks
// horizontal/vertical counters through one full frame, and produces registered
// active-low syncs plus a visible-area flag that gates the renderer's colour.
module vga_sync #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rgb_in,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        p_tick,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick,
    output logic [7:0]  rgb_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_MAX    = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_MAX    = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // A divide-by-one still needs a one-bit register; it simply stays at zero.
    localparam int                DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [10:0]      h_cnt;
    logic [10:0]      v_cnt;
    logic             h_last;
    logic             v_last;

    // Clock divider: counts 0..CLK_DIV-1 and wraps.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign p_tick = (div_cnt == DIV_MAX);
    assign h_last = (h_cnt == H_MAX);
    assign v_last = (v_cnt == V_MAX);

    // Horizontal counter: one step per pixel strobe, wraps at end of line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
        end else if (p_tick) begin
            h_cnt <= h_last ? 11'd0 : h_cnt + 11'd1;
        end
    end

    // Vertical counter: one step per completed line, wraps at end of frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_cnt <= '0;
        end else if (p_tick && h_last) begin
            v_cnt <= v_last ? 11'd0 : v_cnt + 11'd1;
        end
    end

    // Sync and visible-area flags, registered one clk behind x/y so they line
    // up with the renderer's registered colour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
        end else begin
            hsync    <= !((h_cnt >= HS_START) && (h_cnt <= HS_END));
            vsync    <= !((v_cnt >= VS_START) && (v_cnt <= VS_END));
            video_on <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
        end
    end

    // Blank the colour outside the visible area.
    // NOTE: every combinational output is assigned on all paths (here via a
    // full ternary) so no latch is inferred.
    always_comb begin
        rgb_out = video_on ? rgb_in : 8'h00;
    end

    assign x          = h_cnt;
    assign y          = v_cnt;
    assign frame_tick = p_tick && h_last && v_last;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync. Four instances share clk/reset/rgb_in:
//   s: small raster (15x10 totals), CLK_DIV=4  -- full frames, gating, reset
//   f: small raster, CLK_DIV=1                 -- divide-by-one behaviour
//   d: default 800x525, CLK_DIV=4              -- hsync timing of a real line
//   e: default 800x525, CLK_DIV=1              -- hsync period in clks
// Expected values come from the clk count since reset release.
module tb_vga_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rgb_in;

    logic [10:0] s_x, s_y, f_x, f_y, d_x, d_y, e_x, e_y;
    logic        s_p, s_von, s_hs, s_vs, s_ft;
    logic        f_p, f_von, f_hs, f_vs, f_ft;
    logic        d_p, d_von, d_hs, d_vs, d_ft;
    logic        e_p, e_von, e_hs, e_vs, e_ft;
    logic [7:0]  s_rgb, f_rgb, d_rgb, e_rgb;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    vga_sync #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
               .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
               .CLK_DIV(4)) dut_s (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .x(s_x), .y(s_y),
        .p_tick(s_p), .video_on(s_von), .hsync(s_hs), .vsync(s_vs),
        .frame_tick(s_ft), .rgb_out(s_rgb));

    vga_sync #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
               .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
               .CLK_DIV(1)) dut_f (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .x(f_x), .y(f_y),
        .p_tick(f_p), .video_on(f_von), .hsync(f_hs), .vsync(f_vs),
        .frame_tick(f_ft), .rgb_out(f_rgb));

    vga_sync dut_d (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .x(d_x), .y(d_y),
        .p_tick(d_p), .video_on(d_von), .hsync(d_hs), .vsync(d_vs),
        .frame_tick(d_ft), .rgb_out(d_rgb));

    vga_sync #(.CLK_DIV(1)) dut_e (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .x(e_x), .y(e_y),
        .p_tick(e_p), .video_on(e_von), .hsync(e_hs), .vsync(e_vs),
        .frame_tick(e_ft), .rgb_out(e_rgb));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Small raster, CLK_DIV=4: 4 clks/pixel, 60 clks/line, 600 clks/frame.
    // c = number of rising edges since reset release (c >= 1).
    task automatic check_s(input int c);
        int hh, vv;
        logic vis;
        hh  = ((c - 1) / 4) % 15;
        vv  = ((c - 1) / 60) % 10;
        vis = (hh < 8) && (vv < 6);
        check("s_x", 32'(s_x), 32'((c / 4) % 15));
        check("s_y", 32'(s_y), 32'((c / 60) % 10));
        check("s_p_tick", 32'(s_p), 32'(c % 4 == 3));
        check("s_frame_tick", 32'(s_ft), 32'(c % 600 == 599));
        check("s_hsync", 32'(s_hs), 32'(!(hh >= 10 && hh <= 12)));
        check("s_vsync", 32'(s_vs), 32'(!(vv >= 7 && vv <= 8)));
        check("s_video_on", 32'(s_von), 32'(vis));
        check("s_rgb_out", 32'(s_rgb), 32'(vis ? rgb_in : 8'h00));
    endtask

    // Small raster, CLK_DIV=1: 15 clks/line, 150 clks/frame.
    task automatic check_f(input int c);
        int hh, vv;
        hh = (c - 1) % 15;
        vv = ((c - 1) / 15) % 10;
        check("f_x", 32'(f_x), 32'(c % 15));
        check("f_y", 32'(f_y), 32'((c / 15) % 10));
        check("f_p_tick", 32'(f_p), 32'd1);
        check("f_frame_tick", 32'(f_ft), 32'(c % 150 == 149));
        check("f_hsync", 32'(f_hs), 32'(!(hh >= 10 && hh <= 12)));
        check("f_video_on", 32'(f_von), 32'((hh < 8) && (vv < 6)));
    endtask

    // Default raster, CLK_DIV=4: 3200 clks/line.
    task automatic check_d(input int c);
        int hh, vv;
        hh = ((c - 1) / 4) % 800;
        vv = ((c - 1) / 3200) % 525;
        check("d_x", 32'(d_x), 32'((c / 4) % 800));
        check("d_y", 32'(d_y), 32'((c / 3200) % 525));
        check("d_hsync", 32'(d_hs), 32'(!(hh >= 656 && hh <= 751)));
        check("d_vsync", 32'(d_vs), 32'd1);
        check("d_rgb_out", 32'(d_rgb), 32'((hh < 640 && vv < 480) ? rgb_in : 8'h00));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_x"}, 32'(s_x), 32'd0);
        check({tag, "_y"}, 32'(s_y), 32'd0);
        check({tag, "_p_tick"}, 32'(s_p), 32'd0);
        check({tag, "_hsync"}, 32'(s_hs), 32'd1);
        check({tag, "_vsync"}, 32'(s_vs), 32'd1);
        check({tag, "_video_on"}, 32'(s_von), 32'd0);
        check({tag, "_frame_tick"}, 32'(s_ft), 32'd0);
        check({tag, "_rgb_out"}, 32'(s_rgb), 32'd0);
        check({tag, "_f_p_tick"}, 32'(f_p), 32'd1);
        check({tag, "_d_x"}, 32'(d_x), 32'd0);
    endtask

    initial begin
        int d_x656, d_fall1, d_rise1, d_fall2;
        int s_vfall, s_vrise, s_ft_first, s_ft_cnt, e_fall1, e_fall2;
        logic d_hs_q, s_vs_q, e_hs_q;

        d_x656 = -1; d_fall1 = -1; d_rise1 = -1; d_fall2 = -1;
        s_vfall = -1; s_vrise = -1; s_ft_first = -1; s_ft_cnt = 0;
        e_fall1 = -1; e_fall2 = -1;
        d_hs_q = 1'b1; s_vs_q = 1'b1; e_hs_q = 1'b1;

        reset  = 1'b0;
        rgb_in = 8'hA5;
        repeat (3) @(negedge clk);
        check_reset_values("rst");

        // Release between edges; first counted edge is the next rising edge.
        reset = 1'b1;
        cyc = 0;
        check_reset_values("rel0");

        for (int c = 1; c <= 6085; c++) begin
            @(negedge clk);
            cyc = c;
            check_s(c);
            check_f(c);
            check_d(c);
            check("e_x", 32'(e_x), 32'(c % 800));

            if (d_x656 < 0 && d_x == 11'd656) d_x656 = c;
            if (d_hs_q && !d_hs) begin
                if (d_fall1 < 0) d_fall1 = c;
                else if (d_fall2 < 0) d_fall2 = c;
            end
            if (!d_hs_q && d_hs && d_rise1 < 0) d_rise1 = c;
            if (s_vs_q && !s_vs && s_vfall < 0) s_vfall = c;
            if (!s_vs_q && s_vs && s_vrise < 0) s_vrise = c;
            if (e_hs_q && !e_hs) begin
                if (e_fall1 < 0) e_fall1 = c;
                else if (e_fall2 < 0) e_fall2 = c;
            end
            if (s_ft) begin
                s_ft_cnt++;
                if (s_ft_first < 0) s_ft_first = c;
                check("s_ft_at_x", 32'(s_x), 32'd14);
                check("s_ft_at_y", 32'(s_y), 32'd9);
            end
            d_hs_q = d_hs; s_vs_q = s_vs; e_hs_q = e_hs;

            // Second half runs a different colour through the gate.
            rgb_in = (c >= 3000) ? 8'h3C : 8'hA5;
        end

        check("d_x656_cycle", 32'(d_x656), 32'd2624);
        check("d_hsync_fall", 32'(d_fall1), 32'd2625);
        check("d_hsync_low_clks", 32'(d_rise1 - d_fall1), 32'd384);
        check("d_hsync_period", 32'(d_fall2 - d_fall1), 32'd3200);
        check("e_hsync_fall", 32'(e_fall1), 32'd657);
        check("e_hsync_period", 32'(e_fall2 - e_fall1), 32'd800);
        check("s_vsync_fall", 32'(s_vfall), 32'd421);
        check("s_vsync_low_clks", 32'(s_vrise - s_vfall), 32'd120);
        check("s_frame_tick_first", 32'(s_ft_first), 32'd599);
        check("s_frame_tick_count", 32'(s_ft_cnt), 32'd10);

        // Mid-frame: dut_s sits at x=6, y=1 with video_on=1.
        check("pre_rst_video_on", 32'(s_von), 32'd1);
        check("pre_rst_x", 32'(s_x), 32'd6);
        check("pre_rst_y", 32'(s_y), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async");
        @(negedge clk);
        check_reset_values("held");

        reset = 1'b1;
        cyc = 0;
        check_reset_values("rel1");
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            cyc = c;
            check_s(c);
            check_f(c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel (100 MHz to 25 MHz)

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single system clock, rising edge
- reset, in, 1, asynchronous, active-low
- rgb_in, in, 8, pixel colour from the downstream renderer, registered one clk after x/y
- x, out, 11, current horizontal pixel count
- y, out, 11, current vertical line count
- p_tick, out, 1, one-clk pixel-enable strobe
- video_on, out, 1, visible-area flag, aligned with rgb_out
- hsync, out, 1, horizontal sync, active-low
- vsync, out, 1, vertical sync, active-low
- frame_tick, out, 1, one-clk pulse on the last pixel of a frame
- rgb_out, out, 8, gated colour to the VGA connector

Function
REQ-003 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800) SHALL be used; V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525) SHALL be used.
REQ-004 The divider SHALL be a counter 0..CLK_DIV-1, incrementing every clk and wrapping to 0 after CLK_DIV-1.
REQ-005 p_tick SHALL be high exactly when the divider equals CLK_DIV-1 (decoded from registers, no extra delay); with CLK_DIV=1, p_tick SHALL be constantly 1 out of reset.
REQ-006 The h counter SHALL advance only on edges where p_tick=1 and SHALL wrap from H_TOTAL-1 to 0.
REQ-007 The v counter SHALL advance only on edges where p_tick=1 and h=H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-008 x and y SHALL be the h and v counter registers directly, zero-extended to 11 bits.
REQ-009 The hsync register SHALL be loaded every clk with 0 iff H_DISPLAY+H_FRONT <= h <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751), else 1.
REQ-010 The vsync register SHALL be loaded every clk with 0 iff V_DISPLAY+V_FRONT <= v <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491), else 1.
REQ-011 The video_on register SHALL be loaded every clk with (h < H_DISPLAY && v < V_DISPLAY).
REQ-012 hsync, vsync and video_on SHALL lag x/y by exactly one clk, matching the renderer's one-clk rgb register.
REQ-013 rgb_out SHALL equal rgb_in when video_on=1 and 8'h00 otherwise (combinational gate on the registered flag).
REQ-014 frame_tick SHALL be high iff p_tick=1 && h=H_TOTAL-1 && v=V_TOTAL-1, i.e. one clk per frame.
REQ-015 No other state SHALL exist; every state is reachable, and the counters SHALL never exceed their TOTAL-1 values.

Reset
REQ-016 While reset=0, independent of clk: divider=0, h=0, v=0, hsync=1, vsync=1, video_on=0, so x=0, y=0, p_tick=0 (CLK_DIV>1), frame_tick=0, rgb_out=8'h00.
REQ-017 Reset asserted mid-frame SHALL force all REQ-016 values immediately; counting SHALL restart from divider=0 on the first clk edge after release.

Verification
REQ-018 Release reset, CLK_DIV=4 -> p_tick first high in the cycle after the 3rd edge; x=1 after the 4th edge; hsync=vsync=1, rgb_out=0 until video_on rises one clk after reset release.
REQ-019 Run one line -> hsync low for 384 clks starting one clk after x becomes 656; hsync period 3200 clks.
REQ-020 Run one frame -> vsync low for 6400 clks starting one clk after y becomes 490 with x=0; frame_tick pulses once per 1,680,000 clks, while x=799 and y=524.
REQ-021 rgb_in=8'hA5 held -> rgb_out=8'hA5 for x 0..639, y 0..479 (one clk delayed); rgb_out=8'h00 for x 640..799 and for y>=480.
REQ-022 Assert reset asynchronously between edges at x=300, y=200 -> all outputs take REQ-016 values before the next edge; after release, the timing of REQ-018 repeats.
REQ-023 Override CLK_DIV=1 -> p_tick constantly 1; hsync period 800 clks; frame_tick once per 420,000 clks.
